// File: rtl/dvp_pattern_gen.sv
// rtl/dvp_pattern_gen.sv - DVP camera-timing and test-pattern source, byte-serial
//
// Purpose:
//   Generates DVP frame timing (dvp_vsync / dvp_href) and a byte-serial test
//   pattern (dvp_data). One DVP byte is emitted per sys_clk cycle and
//   BYTES_PER_PIX bytes form one pixel. Four runtime pattern modes are
//   supported: ramp, solid colour, vertical gradient and checkerboard.
//
// Ports:
//   sys_clk       clock, one DVP byte per cycle
//   sys_rst       synchronous reset, active-high
//   gen_en        run request; a frame in progress always completes
//   pattern_mode  0 ramp, 1 solid, 2 vertical gradient, 3 checkerboard
//   solid_color   mode-1 pixel value, MSB byte first
//   dvp_href      line valid
//   dvp_vsync     frame sync, active-high
//   dvp_data      pixel byte, 0 whenever dvp_href is low
//   frame_start   1-cycle pulse on the first cycle of a frame
//   frame_done    1-cycle pulse on the last cycle of a frame
//   frame_cnt     completed frames, wraps 0xFFFF -> 0
//   frame_crc     (DVP_PG_CRC_EN only) CRC-16-CCITT of the last frame's href bytes
//
// Configuration macro:
//   DVP_PG_CRC_EN  adds frame_crc output and its CRC logic (needs DATA_WIDTH == 8)

module dvp_pattern_gen #(
    parameter int DATA_WIDTH    = 8,
    parameter int BYTES_PER_PIX = 3,
    parameter int H_VALID       = 400,
    parameter int H_TOTAL       = 440,
    parameter int V_SYNC        = 20,
    parameter int V_BACK        = 20,
    parameter int V_VALID       = 320,
    parameter int V_FRONT       = 20,
    parameter int CHK_LOG2      = 3
) (
    input  logic                                  sys_clk,
    input  logic                                  sys_rst,
    input  logic                                  gen_en,
    input  logic [1:0]                            pattern_mode,
    input  logic [DATA_WIDTH*BYTES_PER_PIX-1:0]   solid_color,
    output logic                                  dvp_href,
    output logic                                  dvp_vsync,
    output logic [DATA_WIDTH-1:0]                 dvp_data,
    output logic                                  frame_start,
    output logic                                  frame_done,
    output logic [15:0]                           frame_cnt
`ifdef DVP_PG_CRC_EN
    ,
    output logic [15:0]                           frame_crc
`endif
);

    localparam int V_TOTAL     = V_SYNC + V_BACK + V_VALID + V_FRONT;
    localparam int H_BYTES     = H_TOTAL * BYTES_PER_PIX;
    localparam int H_ACT       = H_VALID * BYTES_PER_PIX;
    localparam int V_ACT_START = V_SYNC + V_BACK;
    localparam int V_ACT_END   = V_ACT_START + V_VALID;
    localparam int CW          = DATA_WIDTH * BYTES_PER_PIX;

    // One spare count of headroom so every boundary constant fits its counter.
    localparam int HW = $clog2(H_BYTES + 1);
    localparam int VW = $clog2(V_TOTAL + 1);
    localparam int XW = $clog2(H_VALID + 1);
    localparam int YW = $clog2(V_VALID + 1);
    localparam int BW = $clog2(BYTES_PER_PIX + 1);

    localparam logic [HW-1:0] H_LAST   = HW'(H_BYTES - 1);
    localparam logic [HW-1:0] H_ACT_L  = HW'(H_ACT);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_SYNC_L = VW'(V_SYNC);
    localparam logic [VW-1:0] V_AS_L   = VW'(V_ACT_START);
    localparam logic [VW-1:0] V_AE_L   = VW'(V_ACT_END);
    localparam logic [BW-1:0] B_LAST   = BW'(BYTES_PER_PIX - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  state_q, state_d;
    logic [HW-1:0]           cnt_h_q, cnt_h_d;
    logic [VW-1:0]           cnt_v_q, cnt_v_d;
    logic [XW-1:0]           x_q, x_d;
    logic [BW-1:0]           b_q, b_d;
    logic [YW-1:0]           y_q, y_d;
    logic [1:0]              mode_q, mode_d;
    logic [CW-1:0]           color_q, color_d;
    logic                    vsync_q, vsync_d;
    logic                    href_q, href_d;
    logic [DATA_WIDTH-1:0]   data_q, data_d;
    logic                    fstart_q, fstart_d;
    logic                    fdone_q, fdone_d;
    logic [15:0]             fcnt_q, fcnt_d;

    logic                    run;
    logic                    line_end;
    logic                    frame_end;
    logic                    frame_first;
    logic                    h_act;
    logic                    v_act;
    logic [DATA_WIDTH-1:0]   solid_byte;
    logic                    chk_odd;
    logic [DATA_WIDTH-1:0]   pat_byte;

    // Position decode of the current counter state.
    always_comb begin
        run         = (state_q == ST_RUN);
        line_end    = (cnt_h_q == H_LAST);
        frame_end   = line_end && (cnt_v_q == V_LAST);
        frame_first = run && (cnt_h_q == '0) && (cnt_v_q == '0);
        h_act       = (cnt_h_q < H_ACT_L);
        v_act       = (cnt_v_q >= V_AS_L) && (cnt_v_q < V_AE_L);
    end

    // FSM: state register.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state. gen_en is only looked at on frame boundaries so a
    // frame that has started is always emitted in full.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (gen_en) state_d = ST_RUN;
            ST_RUN:  if (frame_end && !gen_en) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Raster counters plus pixel-space counters. x/b/y track the raster
    // position incrementally so no divider by BYTES_PER_PIX is needed.
    always_comb begin
        cnt_h_d = '0;
        cnt_v_d = '0;
        x_d     = '0;
        b_d     = '0;
        y_d     = '0;
        if (run) begin
            if (line_end) begin
                cnt_v_d = frame_end ? '0 : cnt_v_q + 1'b1;
                if (frame_end) begin
                    y_d = '0;
                end else if (v_act) begin
                    y_d = y_q + 1'b1;
                end else begin
                    y_d = y_q;
                end
            end else begin
                cnt_h_d = cnt_h_q + 1'b1;
                cnt_v_d = cnt_v_q;
                y_d     = y_q;
                x_d     = x_q;
                b_d     = b_q;
                if (h_act) begin
                    if (b_q == B_LAST) begin
                        b_d = '0;
                        x_d = x_q + 1'b1;
                    end else begin
                        b_d = b_q + 1'b1;
                    end
                end
            end
        end
    end

    // Pattern controls are captured on the cycle that launches frame_start,
    // so a change mid-frame only takes effect from the next frame.
    always_comb begin
        mode_d  = frame_first ? pattern_mode : mode_q;
        color_d = frame_first ? solid_color  : color_q;
    end

    // Byte b of the solid colour, most significant byte first.
    always_comb begin
        solid_byte = '0;
        for (int i = 0; i < BYTES_PER_PIX; i++) begin
            if (b_q == BW'(i)) begin
                solid_byte = color_q[(BYTES_PER_PIX-1-i)*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // FSM: outputs, computed from the counter state and registered below.
    always_comb begin
        chk_odd = (((x_q >> CHK_LOG2) & XW'(1)) != '0) ^
                  (((y_q >> CHK_LOG2) & YW'(1)) != '0);
        case (mode_q)
            2'd0:    pat_byte = DATA_WIDTH'(cnt_h_q);
            2'd1:    pat_byte = solid_byte;
            2'd2:    pat_byte = DATA_WIDTH'(y_q);
            default: pat_byte = chk_odd ? '1 : '0;
        endcase

        vsync_d  = run && (cnt_v_q < V_SYNC_L);
        href_d   = run && h_act && v_act;
        data_d   = href_d ? pat_byte : '0;
        fstart_d = frame_first;
        fdone_d  = run && frame_end;
        fcnt_d   = fdone_q ? fcnt_q + 1'b1 : fcnt_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_h_q  <= '0;
            cnt_v_q  <= '0;
            x_q      <= '0;
            b_q      <= '0;
            y_q      <= '0;
            mode_q   <= '0;
            color_q  <= '0;
            vsync_q  <= 1'b0;
            href_q   <= 1'b0;
            data_q   <= '0;
            fstart_q <= 1'b0;
            fdone_q  <= 1'b0;
            fcnt_q   <= '0;
        end else begin
            cnt_h_q  <= cnt_h_d;
            cnt_v_q  <= cnt_v_d;
            x_q      <= x_d;
            b_q      <= b_d;
            y_q      <= y_d;
            mode_q   <= mode_d;
            color_q  <= color_d;
            vsync_q  <= vsync_d;
            href_q   <= href_d;
            data_q   <= data_d;
            fstart_q <= fstart_d;
            fdone_q  <= fdone_d;
            fcnt_q   <= fcnt_d;
        end
    end

    assign dvp_href    = href_q;
    assign dvp_vsync   = vsync_q;
    assign dvp_data    = data_q;
    assign frame_start = fstart_q;
    assign frame_done  = fdone_q;
    assign frame_cnt   = fcnt_q;

`ifdef DVP_PG_CRC_EN
    generate
        if (DATA_WIDTH != 8) begin : g_crc_width_check
            $error("dvp_pattern_gen: frame CRC requires DATA_WIDTH == 8");
        end
    endgenerate

    // CRC-16-CCITT, polynomial 0x1021, data shifted in MSB first.
    function automatic logic [15:0] crc16_ccitt_byte(input logic [15:0] crc_in,
                                                     input logic [7:0]  byte_in);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ byte_in[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    logic [15:0] crc_acc_q, crc_acc_d;
    logic [15:0] frame_crc_q, frame_crc_d;

    // The accumulator runs on the registered output stream. frame_start and
    // frame_done never coincide with href, so seeding and publishing never
    // collide with a data byte.
    always_comb begin
        crc_acc_d = crc_acc_q;
        if (fstart_q) begin
            crc_acc_d = 16'hFFFF;
        end else if (href_q) begin
            crc_acc_d = crc16_ccitt_byte(crc_acc_q, 8'(data_q));
        end
        frame_crc_d = fdone_q ? crc_acc_q : frame_crc_q;
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            crc_acc_q   <= '0;
            frame_crc_q <= '0;
        end else begin
            crc_acc_q   <= crc_acc_d;
            frame_crc_q <= frame_crc_d;
        end
    end

    assign frame_crc = frame_crc_q;
`endif

endmodule

// File: tb/tb_dvp_pattern_gen.sv
// tb/tb_dvp_pattern_gen.sv - self-checking bench for dvp_pattern_gen (small geometry)

module tb_dvp_pattern_gen;

    localparam logic [23:0] SOLID = 24'h123456;
    localparam int LINE_CYC  = 18;
    localparam int FRAME_CYC = 126;

    logic        clk;
    logic        sys_rst;
    logic        gen_en;
    logic [1:0]  pattern_mode;
    logic [23:0] solid_color;
    logic        dvp_href;
    logic        dvp_vsync;
    logic [7:0]  dvp_data;
    logic        frame_start;
    logic        frame_done;
    logic [15:0] frame_cnt;
`ifdef DVP_PG_CRC_EN
    logic [15:0] frame_crc;
`endif

    int          n_tests;
    int          n_fail;
    int          fr;
    int          fc;
    logic [15:0] ecrc;

    dvp_pattern_gen #(
        .DATA_WIDTH   (8),
        .BYTES_PER_PIX(3),
        .H_VALID      (4),
        .H_TOTAL      (6),
        .V_SYNC       (2),
        .V_BACK       (1),
        .V_VALID      (3),
        .V_FRONT      (1),
        .CHK_LOG2     (1)
    ) dut (
        .sys_clk     (clk),
        .sys_rst     (sys_rst),
        .gen_en      (gen_en),
        .pattern_mode(pattern_mode),
        .solid_color (solid_color),
        .dvp_href    (dvp_href),
        .dvp_vsync   (dvp_vsync),
        .dvp_data    (dvp_data),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .frame_cnt   (frame_cnt)
`ifdef DVP_PG_CRC_EN
        ,
        .frame_crc   (frame_crc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] crc16(input logic [15:0] crc_in, input logic [7:0] d);
        logic [15:0] c;
        logic        fb;
        c = crc_in;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ d[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    // Expected byte at output position (line, h) of a frame in the given mode.
    function automatic logic [7:0] exp_byte(input int mode, input int line, input int h);
        int x;
        int y;
        int b;
        if (!(h < 12 && line >= 3 && line < 6)) return 8'h00;
        y = line - 3;
        x = h / 3;
        b = h % 3;
        case (mode)
            0:       return 8'(h);
            1:       return 8'(SOLID >> (8 * (2 - b)));
            2:       return 8'(y);
            default: return ((((x >> 1) ^ (y >> 1)) & 1) != 0) ? 8'hFF : 8'h00;
        endcase
    endfunction

    task automatic check_idle(input string name);
        check({name, " vsync"}, 32'(dvp_vsync), 32'(0));
        check({name, " href"},  32'(dvp_href),  32'(0));
        check({name, " data"},  32'(dvp_data),  32'(0));
        check({name, " fstart"}, 32'(frame_start), 32'(0));
        check({name, " fdone"}, 32'(frame_done), 32'(0));
        check({name, " fcnt"},  32'(frame_cnt), 32'(fc));
`ifdef DVP_PG_CRC_EN
        check({name, " crc"},   32'(frame_crc), 32'(ecrc));
`endif
    endtask

    // Steps through n_cyc output cycles of one frame and checks every output.
    // Optional mid-frame actions: change pattern_mode at mode_cyc, drop gen_en at drop_cyc.
    task automatic run_frame(input int mode, input int n_cyc, input int mode_cyc,
                             input int new_mode, input int drop_cyc);
        logic [15:0] crc;
        int          line;
        int          h;
        logic        ehref;
        logic [7:0]  eb;
        string       t;
        crc = 16'hFFFF;
        for (int c = 0; c < n_cyc; c++) begin
            step();
            line  = c / LINE_CYC;
            h     = c % LINE_CYC;
            ehref = (h < 12) && (line >= 3) && (line < 6);
            eb    = exp_byte(mode, line, h);
            t     = $sformatf("f%0d c%0d", fr, c);
            check({t, " vsync"},  32'(dvp_vsync),   32'(line < 2));
            check({t, " href"},   32'(dvp_href),    32'(ehref));
            check({t, " data"},   32'(dvp_data),    32'(eb));
            check({t, " fstart"}, 32'(frame_start), 32'(c == 0));
            check({t, " fdone"},  32'(frame_done),  32'(c == FRAME_CYC - 1));
            check({t, " fcnt"},   32'(frame_cnt),   32'(fc));
`ifdef DVP_PG_CRC_EN
            check({t, " crc"},    32'(frame_crc),   32'(ecrc));
`endif
            if (ehref) crc = crc16(crc, eb);
            if (c == mode_cyc) pattern_mode = 2'(new_mode);
            if (c == drop_cyc) gen_en = 1'b0;
        end
        if (n_cyc == FRAME_CYC) begin
            fc++;
            ecrc = crc;
        end
        fr++;
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        fr           = 0;
        fc           = 0;
        ecrc         = 16'h0000;
        sys_rst      = 1'b1;
        gen_en       = 1'b0;
        pattern_mode = 2'd0;
        solid_color  = SOLID;

        step();
        step();
        check_idle("reset");

        // Leave reset with gen_en high: the first frame starts after the sampling cycle.
        sys_rst = 1'b0;
        gen_en  = 1'b1;
        step();
        check_idle("arm");

        run_frame(0, FRAME_CYC, 60, 1, -1);   // ramp; request solid for next frame
        run_frame(1, FRAME_CYC, 60, 3, -1);   // solid 12,34,56; request checker
        run_frame(3, FRAME_CYC, 10, 0, -1);   // checkerboard; request ramp
        run_frame(0, FRAME_CYC, 40, 2, 50);   // ramp kept after mode->2; gen_en drops at 50

        step();
        check_idle("idle0");
        for (int i = 1; i <= 3; i++) begin
            step();
            check_idle($sformatf("idle%0d", i));
        end

        gen_en = 1'b1;
        step();
        check_idle("rearm");

        run_frame(2, FRAME_CYC, -1, 0, -1);   // vertical gradient 0,1,2
        run_frame(2, 71, -1, 0, -1);          // aborted at cycle 70

        sys_rst = 1'b1;
        gen_en  = 1'b0;
        fc      = 0;
        ecrc    = 16'h0000;
        step();
        check_idle("abort");
        sys_rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_idle($sformatf("post%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
